// File: rtl/led_pattern_pkg.sv
// Shared encodings for the LED pattern engine.
// Mode and FSM state types used by the top and its bench.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'd0,
        MODE_ROTATE  = 2'd1,
        MODE_BOUNCE  = 2'd2,
        MODE_FILL    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

endpackage

// File: rtl/led_pattern_engine_tick_divider.sv
// Programmable step divider: one-cycle tick every (PERIOD >> speed_sel)
// enabled cycles; clr restarts the count from zero.
module tick_divider #(
    parameter int               CNT_W  = 26,
    parameter logic [CNT_W-1:0] PERIOD = 26'h3FFFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] speed_sel,
    output logic       tick
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] limit;

    assign limit = PERIOD >> speed_sel;

    // >= so a live speed-up past the current count fires on the next cycle
    assign tick = en && !clr && (count >= limit - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: oneshot, rotate, bounce and fill patterns
// advanced on each divided tick, with pause and restart control.
module led_pattern_engine
    import led_pattern_pkg::*;
#(
    parameter int               WIDTH  = 16,
    parameter int               CNT_W  = 26,
    parameter logic [CNT_W-1:0] PERIOD = 26'h3FFFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [1:0]       speed_sel,
    output logic [WIDTH-1:0] data_out,
    output logic             step,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] LSB = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state;
    state_e           state_next;
    mode_e            mode_q;
    logic             dir_q;
    logic             bdir;
    logic             bdir_next;
    logic             tick;
    logic             fin;
    logic             done_ev;
    logic             en;
    logic [WIDTH-1:0] pat_next;
    logic [WIDTH-1:0] seed;

    assign busy    = (state != ST_IDLE);
    assign en      = busy && !pause;
    assign seed    = dir ? LSB : MSB;
    assign done_ev = tick && fin;

    tick_divider #(
        .CNT_W  (CNT_W),
        .PERIOD (PERIOD)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (start),
        .speed_sel (speed_sel),
        .tick      (tick)
    );

    always_comb begin
        pat_next  = data_out;
        bdir_next = bdir;
        fin       = 1'b0;
        unique case (mode_q)
            MODE_ONESHOT: begin
                if (dir_q ? data_out[WIDTH-1] : data_out[0]) begin
                    fin = 1'b1;
                end else begin
                    pat_next = dir_q ? data_out << 1 : data_out >> 1;
                end
            end
            MODE_ROTATE: begin
                pat_next = dir_q ? {data_out[WIDTH-2:0], data_out[WIDTH-1]}
                                 : {data_out[0], data_out[WIDTH-1:1]};
            end
            MODE_BOUNCE: begin
                // Reverse before moving when already sitting on the end
                if (bdir ? data_out[WIDTH-1] : data_out[0]) begin
                    bdir_next = ~bdir;
                end
                pat_next = bdir_next ? data_out << 1 : data_out >> 1;
            end
            MODE_FILL: begin
                if (&data_out) begin
                    pat_next = '0;
                end else if (data_out == '0) begin
                    pat_next = dir_q ? LSB : MSB;
                end else if (dir_q) begin
                    pat_next = (data_out << 1) | data_out;
                end else begin
                    pat_next = (data_out >> 1) | data_out;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (start)        state_next = ST_RUN;
                else if (done_ev) state_next = ST_IDLE;
                else if (pause)   state_next = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (start)        state_next = ST_RUN;
                else if (done_ev) state_next = ST_IDLE;
                else if (!pause)  state_next = ST_RUN;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= MSB;
            mode_q   <= MODE_ONESHOT;
            dir_q    <= 1'b0;
            bdir     <= 1'b0;
            step     <= 1'b0;
            done     <= 1'b0;
        end else begin
            step <= 1'b0;
            done <= 1'b0;
            if (start) begin
                data_out <= seed;
                mode_q   <= mode_e'(mode);
                dir_q    <= dir;
                bdir     <= dir;
            end else if (tick) begin
                if (fin) begin
                    done <= 1'b1;
                end else begin
                    data_out <= pat_next;
                    bdir     <= bdir_next;
                    step     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine at WIDTH=8, PERIOD=8.
module tb_led_pattern_engine;

    localparam int               W   = 8;
    localparam int               CW  = 8;
    localparam logic [CW-1:0]    PER = 8'd8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         pause;
    logic [1:0]   mode;
    logic         dir;
    logic [1:0]   speed_sel;
    logic [W-1:0] data_out;
    logic         step;
    logic         busy;
    logic         done;

    int           passed = 0;
    int           total  = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    led_pattern_engine #(
        .WIDTH  (W),
        .CNT_W  (CW),
        .PERIOD (PER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause     (pause),
        .mode      (mode),
        .dir       (dir),
        .speed_sel (speed_sel),
        .data_out  (data_out),
        .step      (step),
        .busy      (busy),
        .done      (done)
    );

    task automatic wait_sig(input bit on_done, input int budget,
                            output int gap, output bit ok);
        ok  = 1'b0;
        gap = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (on_done ? done : step) begin
                gap = i;
                ok  = 1'b1;
                return;
            end
        end
    endtask

    task automatic do_start(input logic [1:0] m, input logic d);
        start = 1'b1;
        mode  = m;
        dir   = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1; start = 1'b0; pause = 1'b0;
        mode = 2'd0; dir = 1'b0; speed_sel = 2'd0;
        repeat (2) @(negedge clk);
        total++;
        if (data_out !== 8'h80) $display("FAIL reset_data got %h want 80", data_out);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
        else passed++;
        total++;
        if (step !== 1'b0) $display("FAIL reset_step got %b want 0", step);
        else passed++;
        total++;
        if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done);
        else passed++;
        rst = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (data_out !== 8'h80 || step !== 1'b0 || busy !== 1'b0) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL idle_hold got %0d bad cycles want 0", bad);
        else passed++;
    endtask

    task automatic test_oneshot();
        int gap; bit ok; logic [W-1:0] e;
        do_start(2'd0, 1'b0);
        total++;
        if (data_out !== 8'h80 || busy !== 1'b1)
            $display("FAIL oneshot_seed got %h/%b want 80/1", data_out, busy);
        else passed++;
        for (int k = 1; k <= 7; k++) exp_q.push_back(8'h80 >> k);
        for (int k = 1; k <= 7; k++) begin
            wait_sig(1'b0, 20, gap, ok);
            total++;
            if (!ok || gap !== 8) $display("FAIL oneshot_gap%0d got %0d want 8", k, gap);
            else passed++;
            e = exp_q.pop_front();
            total++;
            if (data_out !== e) $display("FAIL oneshot_val%0d got %h want %h", k, data_out, e);
            else passed++;
        end
        wait_sig(1'b1, 20, gap, ok);
        total++;
        if (!ok || gap !== 8) $display("FAIL oneshot_done_gap got %0d want 8", gap);
        else passed++;
        total++;
        if (busy !== 1'b0 || step !== 1'b0 || data_out !== 8'h01)
            $display("FAIL oneshot_end got busy=%b step=%b data=%h want 0/0/01",
                     busy, step, data_out);
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || data_out !== 8'h01)
            $display("FAIL oneshot_after got done=%b data=%h want 0/01", done, data_out);
        else passed++;
    endtask

    task automatic test_rotate();
        int gap; bit ok; logic [W-1:0] e; int want;
        logic [W-1:0] one = 8'd1;
        do_start(2'd1, 1'b1);
        total++;
        if (data_out !== 8'h01) $display("FAIL rotate_seed got %h want 01", data_out);
        else passed++;
        for (int k = 1; k <= 9; k++) exp_q.push_back(one << (k % 8));
        for (int k = 1; k <= 9; k++) begin
            wait_sig(1'b0, 20, gap, ok);
            total++;
            if (!ok || gap !== 8) $display("FAIL rotate_gap%0d got %0d want 8", k, gap);
            else passed++;
            e = exp_q.pop_front();
            total++;
            if (data_out !== e) $display("FAIL rotate_val%0d got %h want %h", k, data_out, e);
            else passed++;
        end
        repeat (5) @(negedge clk);
        speed_sel = 2'd2;
        for (int k = 10; k <= 13; k++) exp_q.push_back(one << (k % 8));
        for (int j = 0; j < 4; j++) begin
            want = (j == 0) ? 1 : 2;
            wait_sig(1'b0, 20, gap, ok);
            total++;
            if (!ok || gap !== want)
                $display("FAIL rotate_fast_gap%0d got %0d want %0d", j, gap, want);
            else passed++;
            e = exp_q.pop_front();
            total++;
            if (data_out !== e) $display("FAIL rotate_fast_val%0d got %h want %h", j, data_out, e);
            else passed++;
        end
        speed_sel = 2'd0;
    endtask

    task automatic test_bounce();
        int gap; bit ok; logic [W-1:0] e; int t; int pos;
        logic [W-1:0] one = 8'd1;
        do_start(2'd2, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            t   = k % 14;
            pos = (t <= 7) ? 7 - t : t - 7;
            exp_q.push_back(one << pos);
        end
        for (int k = 1; k <= 16; k++) begin
            wait_sig(1'b0, 20, gap, ok);
            total++;
            if (!ok || gap !== 8) $display("FAIL bounce_gap%0d got %0d want 8", k, gap);
            else passed++;
            e = exp_q.pop_front();
            total++;
            if (data_out !== e) $display("FAIL bounce_val%0d got %h want %h", k, data_out, e);
            else passed++;
        end
    endtask

    task automatic test_fill_pause();
        int gap; bit ok; logic [W-1:0] e; int t; int want; int bad;
        logic [W-1:0] held;
        do_start(2'd3, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            t = k % 9;
            exp_q.push_back((t == 8) ? 8'h00 : 8'((1 << (t + 1)) - 1));
        end
        for (int k = 1; k <= 10; k++) begin
            want = 8;
            if (k == 5) begin
                repeat (3) @(negedge clk);
                pause = 1'b1;
                held  = data_out;
                bad   = 0;
                repeat (50) begin
                    @(negedge clk);
                    if (step !== 1'b0 || data_out !== held || busy !== 1'b1) bad++;
                end
                pause = 1'b0;
                total++;
                if (bad !== 0) $display("FAIL pause_freeze got %0d bad cycles want 0", bad);
                else passed++;
                want = 5;
            end
            wait_sig(1'b0, 20, gap, ok);
            total++;
            if (!ok || gap !== want) $display("FAIL fill_gap%0d got %0d want %0d", k, gap, want);
            else passed++;
            e = exp_q.pop_front();
            total++;
            if (data_out !== e) $display("FAIL fill_val%0d got %h want %h", k, data_out, e);
            else passed++;
        end
    endtask

    task automatic test_restart();
        int gap; bit ok; logic [W-1:0] e; int bad;
        repeat (3) @(negedge clk);
        do_start(2'd0, 1'b1);
        total++;
        if (data_out !== 8'h01 || busy !== 1'b1)
            $display("FAIL restart_seed got %h/%b want 01/1", data_out, busy);
        else passed++;
        exp_q.push_back(8'h02);
        wait_sig(1'b0, 20, gap, ok);
        total++;
        if (!ok || gap !== 8) $display("FAIL restart_gap got %0d want 8", gap);
        else passed++;
        e = exp_q.pop_front();
        total++;
        if (data_out !== e) $display("FAIL restart_val got %h want %h", data_out, e);
        else passed++;
        pause = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (busy !== 1'b1 || data_out !== 8'h02)
            $display("FAIL paused_state got %b/%h want 1/02", busy, data_out);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (data_out !== 8'h80 || busy !== 1'b0 || step !== 1'b0)
            $display("FAIL mid_reset got %h/%b/%b want 80/0/0", data_out, busy, step);
        else passed++;
        rst   = 1'b0;
        pause = 1'b0;
        bad   = 0;
        repeat (20) begin
            @(negedge clk);
            if (step !== 1'b0 || busy !== 1'b0 || data_out !== 8'h80) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL post_reset_idle got %0d bad cycles want 0", bad);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_rotate();
        test_bounce();
        test_fill_pause();
        test_restart();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
